// File: rtl/servo_pwm_gen_if.sv
// Position command handshake between a command source and the servo PWM generator.
// A command transfers on any clock where i_Pos_Valid and o_Pos_Ready are both high.
interface servo_pwm_gen_if;
  logic       i_Pos_Valid;
  logic [7:0] i_Pos;
  logic       o_Pos_Ready;

  modport master (output i_Pos_Valid, output i_Pos, input o_Pos_Ready);
  modport slave  (input i_Pos_Valid, input i_Pos, output o_Pos_Ready);
endinterface

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: buffers position commands, slews the pulse width once per frame,
// compares it against the upstream frame count and blanks the output if frames stop.
module servo_pwm_gen #(
  parameter int MIN_WIDTH     = 100000,
  parameter int STEP          = 392,
  parameter int MAX_WIDTH     = 200000,
  parameter int SLEW          = 2000,
  parameter int FRAME_TIMEOUT = 1100000
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  input  logic [19:0]     i_Count,
  servo_pwm_gen_if.slave  io_Pos,
  output logic            o_Pwm,
  output logic            o_At_Target,
  output logic            o_Fault
);

  localparam int              WD_W        = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX      = WD_W'(FRAME_TIMEOUT);
  localparam logic [20:0]     RESET_WIDTH = 21'(MIN_WIDTH + 128 * STEP);
  localparam logic [20:0]     SLEW_W      = 21'(SLEW);

  logic [19:0]     r_PrevCount;
  logic            r_PendValid;
  logic [7:0]      r_PendPos;
  logic [20:0]     r_TgtW;
  logic [20:0]     r_CurW;
  logic [WD_W-1:0] r_WdCnt;

  logic            w_Fs;
  logic            w_Accept;
  logic            w_Load;
  logic [19:0]     w_MapRaw;
  logic [20:0]     w_MapW;
  logic [20:0]     w_TgtNext;
  logic [20:0]     w_CurNext;
  logic [WD_W-1:0] w_WdNext;
  logic            w_FaultNext;
  logic            w_PwmNext;

  // A held-zero count produces only one frame start because prev_count follows it.
  assign w_Fs     = (i_Count == 20'd0) && (r_PrevCount != 20'd0);
  assign w_Accept = io_Pos.i_Pos_Valid && !r_PendValid;
  assign w_Load   = w_Fs && r_PendValid;

  assign io_Pos.o_Pos_Ready = !r_PendValid;

  always_comb begin
    w_MapRaw = 20'(MIN_WIDTH) + 20'(r_PendPos) * 20'(STEP);
    w_MapW   = {1'b0, w_MapRaw};
    if (w_MapRaw > 20'(MAX_WIDTH)) begin
      w_MapW = 21'(MAX_WIDTH);
    end
  end

  assign w_TgtNext = w_Load ? w_MapW : r_TgtW;

  // Differences are formed before stepping so the 21-bit math never wraps.
  always_comb begin
    w_CurNext = r_CurW;
    if (w_Fs) begin
      if (r_CurW < w_TgtNext) begin
        w_CurNext = ((w_TgtNext - r_CurW) > SLEW_W) ? (r_CurW + SLEW_W) : w_TgtNext;
      end else if (r_CurW > w_TgtNext) begin
        w_CurNext = ((r_CurW - w_TgtNext) > SLEW_W) ? (r_CurW - SLEW_W) : w_TgtNext;
      end
    end
  end

  always_comb begin
    w_WdNext = r_WdCnt;
    if (w_Fs) begin
      w_WdNext = '0;
    end else if (r_WdCnt != WD_MAX) begin
      w_WdNext = r_WdCnt + WD_W'(1);
    end
  end

  assign w_FaultNext = !w_Fs && (w_WdNext == WD_MAX);
  assign w_PwmNext   = ({1'b0, i_Count} < r_CurW) && !w_FaultNext;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_PrevCount <= 20'hFFFFF;
      r_PendValid <= 1'b0;
      r_PendPos   <= 8'd0;
      r_TgtW      <= RESET_WIDTH;
      r_CurW      <= RESET_WIDTH;
      r_WdCnt     <= '0;
      o_Pwm       <= 1'b0;
      o_At_Target <= 1'b1;
      o_Fault     <= 1'b0;
    end else begin
      r_PrevCount <= i_Count;
      if (w_Load) begin
        r_PendValid <= 1'b0;
      end else if (w_Accept) begin
        r_PendValid <= 1'b1;
        r_PendPos   <= io_Pos.i_Pos;
      end
      r_TgtW      <= w_TgtNext;
      r_CurW      <= w_CurNext;
      r_WdCnt     <= w_WdNext;
      o_Pwm       <= w_PwmNext;
      o_At_Target <= (w_CurNext == w_TgtNext);
      o_Fault     <= w_FaultNext;
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen: short synthetic frames driven on i_Count,
// with pulse width probed at the cur_w-1 / cur_w boundary each frame.
module tb_servo_pwm_gen;

  localparam int TB_TIMEOUT = 64;

  typedef struct {
    bit         doReset;
    bit         send;
    logic [7:0] pos;
    int         expCur;
    bit         expAt;
  } frame_vec_t;

  logic        clk;
  logic        rst_n;
  logic [19:0] count;
  logic        pwm;
  logic        atTarget;
  logic        fault;
  int          nChecks;
  int          nErrors;
  frame_vec_t  vecs[$];

  servo_pwm_gen_if posIf ();

  servo_pwm_gen #(.FRAME_TIMEOUT(TB_TIMEOUT)) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_Count     (count),
    .io_Pos      (posIf.slave),
    .o_Pwm       (pwm),
    .o_At_Target (atTarget),
    .o_Fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [19:0] c);
    count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    count = 20'd777;
    posIf.i_Pos_Valid = 1'b0;
    posIf.i_Pos = 8'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("reset_pwm", pwm, 1'b0);
    checkOutput("reset_at_target", atTarget, 1'b1);
    checkOutput("reset_fault", fault, 1'b0);
    checkOutput("reset_ready", posIf.o_Pos_Ready, 1'b1);
  endtask

  task automatic sendPos(input logic [7:0] p);
    checkOutput("ready_before_send", posIf.o_Pos_Ready, 1'b1);
    posIf.i_Pos = p;
    posIf.i_Pos_Valid = 1'b1;
    applyStimulus(20'd400000);
    posIf.i_Pos_Valid = 1'b0;
    checkOutput("ready_low_after_accept", posIf.o_Pos_Ready, 1'b0);
  endtask

  // One short frame: FS, then probe the high/low boundary of the width just applied.
  task automatic runFrame(input int expCur, input bit expAt, input string tag);
    applyStimulus(20'd0);
    checkOutput({tag, "_at_target"}, atTarget, expAt);
    checkOutput({tag, "_ready_after_fs"}, posIf.o_Pos_Ready, 1'b1);
    applyStimulus(20'(expCur - 1));
    checkOutput({tag, "_pwm_hi"}, pwm, 1'b1);
    applyStimulus(20'(expCur));
    checkOutput({tag, "_pwm_lo"}, pwm, 1'b0);
    applyStimulus(20'd999999);
  endtask

  initial begin
    nChecks = 0;
    nErrors = 0;
    rst_n = 1'b0;
    count = 20'd777;
    posIf.i_Pos_Valid = 1'b0;
    posIf.i_Pos = 8'd0;

    // Idle frame at the reset width, then position 200 (target 178400), then position 0 (target 100000).
    vecs.push_back('{1'b1, 1'b0, 8'd0, 150176, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 8'd200, 152176, 1'b0});
    for (int k = 2; k <= 14; k++) vecs.push_back('{1'b0, 1'b0, 8'd0, 150176 + 2000 * k, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'd0, 178400, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 8'd0, 148176, 1'b0});
    for (int k = 2; k <= 25; k++) vecs.push_back('{1'b0, 1'b0, 8'd0, 150176 - 2000 * k, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'd0, 100000, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].doReset) doReset();
      if (vecs[i].send) sendPos(vecs[i].pos);
      runFrame(vecs[i].expCur, vecs[i].expAt, $sformatf("vec%0d", i));
    end

    // Position 255 mid-frame, position 10 held while stalled, accepted right after FS.
    doReset();
    posIf.i_Pos = 8'd255;
    posIf.i_Pos_Valid = 1'b1;
    applyStimulus(20'd300000);
    checkOutput("stall_ready_low", posIf.o_Pos_Ready, 1'b0);
    posIf.i_Pos = 8'd10;
    applyStimulus(20'd300001);
    applyStimulus(20'd300002);
    checkOutput("stall_still_low", posIf.o_Pos_Ready, 1'b0);
    applyStimulus(20'd0);
    checkOutput("stall_ready_after_fs", posIf.o_Pos_Ready, 1'b1);
    checkOutput("stall_at_target_fs1", atTarget, 1'b0);
    applyStimulus(20'd152175);
    checkOutput("stall_accept_10", posIf.o_Pos_Ready, 1'b0);
    checkOutput("stall_fs1_pwm_hi", pwm, 1'b1);
    posIf.i_Pos_Valid = 1'b0;
    applyStimulus(20'd152176);
    checkOutput("stall_fs1_pwm_lo", pwm, 1'b0);
    applyStimulus(20'd900000);
    applyStimulus(20'd0);
    checkOutput("stall_ready_after_fs2", posIf.o_Pos_Ready, 1'b1);
    applyStimulus(20'd150175);
    checkOutput("stall_fs2_pwm_hi", pwm, 1'b1);
    applyStimulus(20'd150176);
    checkOutput("stall_fs2_pwm_lo", pwm, 1'b0);
    applyStimulus(20'd900000);
    checkOutput("stall_no_duplicate", posIf.o_Pos_Ready, 1'b1);
    for (int n = 3; n <= 26; n++) begin
      int e;
      e = 152176 - 2000 * (n - 1);
      if (e < 103920) e = 103920;
      runFrame(e, e == 103920, $sformatf("down%0d", n));
    end

    // Accept in the FS cycle: target unchanged this frame, loads at the next FS.
    doReset();
    applyStimulus(20'd300);
    posIf.i_Pos = 8'd0;
    posIf.i_Pos_Valid = 1'b1;
    applyStimulus(20'd0);
    posIf.i_Pos_Valid = 1'b0;
    checkOutput("fsacc_ready_low", posIf.o_Pos_Ready, 1'b0);
    checkOutput("fsacc_at_target", atTarget, 1'b1);
    applyStimulus(20'd150175);
    checkOutput("fsacc_pwm_hi", pwm, 1'b1);
    applyStimulus(20'd150176);
    checkOutput("fsacc_pwm_lo", pwm, 1'b0);
    applyStimulus(20'd999999);
    checkOutput("fsacc_ready_frame_end", posIf.o_Pos_Ready, 1'b0);
    runFrame(148176, 1'b0, "fsacc_next");

    // Count stuck at zero: one FS, then the watchdog trips after TB_TIMEOUT clocks.
    doReset();
    applyStimulus(20'd500);
    applyStimulus(20'd0);
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(20'd0);
      if ((i >= 60 && i <= 70) || i == 100) begin
        checkOutput($sformatf("wd_fault_%0d", i), fault, i >= TB_TIMEOUT);
        checkOutput($sformatf("wd_pwm_%0d", i), pwm, i < TB_TIMEOUT);
      end
    end
    posIf.i_Pos = 8'd0;
    posIf.i_Pos_Valid = 1'b1;
    applyStimulus(20'd5);
    posIf.i_Pos_Valid = 1'b0;
    checkOutput("wd_release_fault", fault, 1'b1);
    checkOutput("wd_release_pwm", pwm, 1'b0);
    checkOutput("wd_accept_in_fault", posIf.o_Pos_Ready, 1'b0);
    applyStimulus(20'd0);
    checkOutput("wd_fs_clears_fault", fault, 1'b0);
    checkOutput("wd_fs_pwm", pwm, 1'b1);
    applyStimulus(20'd148175);
    checkOutput("wd_resume_pwm_hi", pwm, 1'b1);
    applyStimulus(20'd148176);
    checkOutput("wd_resume_pwm_lo", pwm, 1'b0);

    // Reset asserted mid-pulse drops the line without waiting for a clock.
    applyStimulus(20'd0);
    applyStimulus(20'd1000);
    checkOutput("midreset_pwm_before", pwm, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_pwm_async", pwm, 1'b0);
    checkOutput("midreset_at_target", atTarget, 1'b1);
    checkOutput("midreset_ready", posIf.o_Pos_Ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sendPos(8'd0);
    runFrame(148176, 1'b0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
